// File: rtl/edge_request_scheduler_if.sv
// Handshake/status bundle between the request scheduler and its environment.
// The master drives the trigger lines and done, and the slave (the scheduler)
// drives the grant, status and error outputs.
interface edge_request_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0] req_in;
    logic             done;
    logic             start;
    logic [ID_W-1:0]  grant_id;
    logic             busy;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] overrun;
    logic             timeout_err;

    modport master (
        output req_in, done,
        input  start, grant_id, busy, pending, overrun, timeout_err
    );

    modport slave (
        input  req_in, done,
        output start, grant_id, busy, pending, overrun, timeout_err
    );
endinterface

// File: rtl/edge_request_scheduler.sv
// Round-robin scheduler for one shared resource. Trigger lines are
// synchronised, rising-edge detected and latched as pending requests. Each
// request is served with a start pulse and a done handshake that is guarded
// by a watchdog.
module edge_request_scheduler #(
    parameter int N_REQ          = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    edge_request_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [N_REQ-1:0] r_a, r_b, r_c;
    logic [N_REQ-1:0] r_pending, r_overrun;
    logic [ID_W-1:0]  r_last, r_grant;
    logic [TO_W-1:0]  r_cnt;
    logic             r_start, r_busy, r_timeout;

    logic [N_REQ-1:0] w_rise, w_clr;
    logic [ID_W-1:0]  w_sel;
    logic             w_found;

    assign w_rise = r_b & ~r_c;

    // Two-flop synchroniser plus one history flop per line for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end else begin
            r_a <= bus.req_in;
            r_b <= r_a;
            r_c <= r_b;
        end
    end

    // Round-robin pick: first pending channel after the last one granted.
    always_comb begin : p_sel
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(r_last) + 1 + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            for (int j = 0; j < N_REQ; j++) begin
                if (!w_found && (j == idx) && r_pending[j]) begin
                    w_found = 1'b1;
                    w_sel   = ID_W'(j);
                end
            end
        end
    end

    // One-hot clear of the channel being granted this cycle.
    always_comb begin
        w_clr = '0;
        for (int j = 0; j < N_REQ; j++)
            w_clr[j] = (r_state == IDLE) && w_found && (w_sel == ID_W'(j));
    end

    // Pending latch: a new edge beats a same-cycle grant clear; an edge on an
    // already-pending, not-clearing channel is recorded as a sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_overrun <= r_overrun | (w_rise & r_pending & ~w_clr);
        end
    end

    // Grant/handshake FSM with registered start, busy and timeout outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= ID_W'(N_REQ - 1);
            r_grant   <= '0;
            r_cnt     <= '0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_sel;
                        r_last  <= w_sel;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    // done arriving here belongs to no launched job; drop it
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (bus.done) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt == LAST_CNT) begin
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.start       = r_start;
    assign bus.grant_id    = r_grant;
    assign bus.busy        = r_busy;
    assign bus.pending     = r_pending;
    assign bus.overrun     = r_overrun;
    assign bus.timeout_err = r_timeout;

endmodule

// File: tb/tb_edge_request_scheduler.sv
// Directed bench for edge_request_scheduler with a short watchdog
// (TIMEOUT_CYCLES = 8). Inputs change and outputs are sampled 1 ns after
// each rising clock edge.
module tb_edge_request_scheduler;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    edge_request_scheduler_if #(.N_REQ(N), .ID_W(2)) bif ();

    edge_request_scheduler #(
        .N_REQ(N), .ID_W(2), .TIMEOUT_CYCLES(8), .TO_W(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] req);
        rst = 1'b1;
        bif.req_in = req;
        bif.done = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic pulse_req(input logic [N-1:0] req);
        bif.req_in = req;
        tick();
        bif.req_in = '0;
    endtask

    task automatic pulse_done();
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bif.start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.req_in = '0;
        bif.done = 1'b0;
        repeat (3) tick();
        n_chk++;
        if ({bif.start, bif.busy, bif.grant_id, bif.pending, bif.overrun, bif.timeout_err} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected all zero",
                {bif.start, bif.busy, bif.grant_id, bif.pending, bif.overrun, bif.timeout_err});
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset('0);
        tick();
        bif.req_in = 4'b0100;
        tick();  // edge k samples the line
        tick();  // k+1
        n_chk++;
        if (bif.pending !== 4'b0000) begin n_fail++; $display("FAIL single_pending_early: got %b expected 0000", bif.pending); end
        tick();  // k+2
        n_chk++;
        if (bif.pending !== 4'b0100) begin n_fail++; $display("FAIL single_pending: got %b expected 0100", bif.pending); end
        tick();  // k+3 grant
        n_chk++;
        if ({bif.start, bif.busy, bif.grant_id} !== {1'b1, 1'b1, 2'd2}) begin
            n_fail++; $display("FAIL single_grant: got start=%b busy=%b id=%0d expected 1 1 2", bif.start, bif.busy, bif.grant_id);
        end
        bif.done = 1'b1;  // done in START must be ignored
        tick();
        bif.done = 1'b0;
        bif.req_in = '0;
        n_chk++;
        if ({bif.start, bif.busy} !== 2'b01) begin n_fail++; $display("FAIL single_start_one_cycle: got start=%b busy=%b expected 0 1", bif.start, bif.busy); end
        repeat (3) tick();
        n_chk++;
        if (bif.busy !== 1'b1) begin n_fail++; $display("FAIL done_in_start_ignored: got busy=%b expected 1", bif.busy); end
        pulse_done();
        n_chk++;
        if ({bif.busy, bif.start, bif.timeout_err, bif.pending} !== 7'b0) begin
            n_fail++; $display("FAIL single_done_idle: got busy=%b start=%b to=%b pend=%b expected all 0", bif.busy, bif.start, bif.timeout_err, bif.pending);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp1 [3] = '{2'd0, 2'd1, 2'd3};
        logic [1:0] exp2 [2] = '{2'd0, 2'd3};
        bit ok;
        do_reset('0);
        tick();
        pulse_req(4'b1011);
        for (int i = 0; i < 3; i++) begin
            wait_start(ok);
            n_chk++;
            if (!ok || bif.grant_id !== exp1[i]) begin
                n_fail++; $display("FAIL rr_first[%0d]: got started=%0d id=%0d expected 1 %0d", i, ok, bif.grant_id, exp1[i]);
            end
            repeat (4) tick();
            pulse_done();
        end
        pulse_req(4'b1001);
        for (int i = 0; i < 2; i++) begin
            wait_start(ok);
            n_chk++;
            if (!ok || bif.grant_id !== exp2[i]) begin
                n_fail++; $display("FAIL rr_second[%0d]: got started=%0d id=%0d expected 1 %0d", i, ok, bif.grant_id, exp2[i]);
            end
            repeat (4) tick();
            pulse_done();
        end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset('0);
        tick();
        pulse_req(4'b0010);
        wait_start(ok);
        n_chk++;
        if (!ok || bif.grant_id !== 2'd1) begin n_fail++; $display("FAIL to_grant: got started=%0d id=%0d expected 1 1", ok, bif.grant_id); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_chk++;
            if ({bif.busy, bif.timeout_err} !== 2'b10) begin
                n_fail++; $display("FAIL to_wait[%0d]: got busy=%b to=%b expected 1 0", i, bif.busy, bif.timeout_err);
            end
        end
        tick();
        n_chk++;
        if ({bif.busy, bif.timeout_err} !== 2'b01) begin n_fail++; $display("FAIL to_pulse: got busy=%b to=%b expected 0 1", bif.busy, bif.timeout_err); end
        tick();
        n_chk++;
        if ({bif.timeout_err, bif.start} !== 2'b00) begin n_fail++; $display("FAIL to_pulse_end: got to=%b start=%b expected 0 0", bif.timeout_err, bif.start); end
        pulse_req(4'b1000);
        wait_start(ok);
        n_chk++;
        if (!ok || bif.grant_id !== 2'd3) begin n_fail++; $display("FAIL to_next_grant: got started=%0d id=%0d expected 1 3", ok, bif.grant_id); end
        tick();
        pulse_done();
        n_chk++;
        if ({bif.busy, bif.timeout_err} !== 2'b00) begin n_fail++; $display("FAIL to_next_done: got busy=%b to=%b expected 0 0", bif.busy, bif.timeout_err); end
    endtask

    task automatic test_overrun();
        bit ok;
        do_reset('0);
        tick();
        pulse_req(4'b0100);
        wait_start(ok);
        for (int p = 0; p < 3; p++) begin
            pulse_req(4'b0010);
            tick();
        end
        tick();
        n_chk++;
        if ({bif.pending[1], bif.overrun, bif.busy} !== {1'b1, 4'b0010, 1'b1}) begin
            n_fail++; $display("FAIL overrun_set: got pend1=%b ovr=%b busy=%b expected 1 0010 1", bif.pending[1], bif.overrun, bif.busy);
        end
        pulse_done();
        wait_start(ok);
        n_chk++;
        if (!ok || bif.grant_id !== 2'd1 || bif.pending[1] !== 1'b0) begin
            n_fail++; $display("FAIL overrun_serve: got started=%0d id=%0d pend1=%b expected 1 1 0", ok, bif.grant_id, bif.pending[1]);
        end
        tick();
        pulse_done();
        n_chk++;
        if (bif.overrun !== 4'b0010) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 0010", bif.overrun); end
    endtask

    task automatic test_set_wins();
        bit ok;
        do_reset('0);
        tick();
        pulse_req(4'b1000);
        wait_start(ok);              // edge S, channel 3 running
        pulse_req(4'b0001);          // S+1
        tick();                      // S+2
        tick();                      // S+3
        n_chk++;
        if (bif.pending !== 4'b0001) begin n_fail++; $display("FAIL sw_pending: got %b expected 0001", bif.pending); end
        pulse_req(4'b0001);          // S+4, rise lands in the cycle after S+5
        pulse_done();                // S+5 back to IDLE
        tick();                      // S+6 grant 0 with coincident rise
        n_chk++;
        if ({bif.start, bif.grant_id, bif.pending[0], bif.overrun} !== {1'b1, 2'd0, 1'b1, 4'b0000}) begin
            n_fail++; $display("FAIL set_wins: got start=%b id=%0d pend0=%b ovr=%b expected 1 0 1 0000",
                bif.start, bif.grant_id, bif.pending[0], bif.overrun);
        end
        tick();
        pulse_done();
        wait_start(ok);
        n_chk++;
        if (!ok || bif.grant_id !== 2'd0 || bif.pending !== 4'b0000) begin
            n_fail++; $display("FAIL sw_reserve: got started=%0d id=%0d pend=%b expected 1 0 0000", ok, bif.grant_id, bif.pending);
        end
        tick();
        pulse_done();
    endtask

    task automatic test_boundary();
        bit ok;
        int nstart;
        do_reset('0);
        repeat (2) tick();
        pulse_done();
        repeat (2) tick();
        n_chk++;
        if ({bif.start, bif.busy} !== 2'b00) begin n_fail++; $display("FAIL done_in_idle: got start=%b busy=%b expected 0 0", bif.start, bif.busy); end
        pulse_req(4'b0001);
        wait_start(ok);
        repeat (8) tick();
        pulse_done();                // sampled on the final watchdog cycle
        n_chk++;
        if ({bif.busy, bif.timeout_err} !== 2'b00) begin n_fail++; $display("FAIL done_vs_timeout: got busy=%b to=%b expected 0 0", bif.busy, bif.timeout_err); end
        tick();
        n_chk++;
        if (bif.timeout_err !== 1'b0) begin n_fail++; $display("FAIL done_vs_timeout_late: got to=%b expected 0", bif.timeout_err); end
        // line held high across reset release yields exactly one request
        do_reset(4'b1000);
        tick();
        tick();
        n_chk++;
        if (bif.pending !== 4'b0000) begin n_fail++; $display("FAIL held_pending_early: got %b expected 0000", bif.pending); end
        tick();
        n_chk++;
        if (bif.pending !== 4'b1000) begin n_fail++; $display("FAIL held_pending: got %b expected 1000", bif.pending); end
        tick();
        n_chk++;
        if ({bif.start, bif.grant_id} !== {1'b1, 2'd3}) begin n_fail++; $display("FAIL held_grant: got start=%b id=%0d expected 1 3", bif.start, bif.grant_id); end
        tick();
        pulse_done();
        nstart = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bif.start === 1'b1) nstart++;
        end
        n_chk++;
        if (nstart !== 0 || bif.pending !== 4'b0000) begin
            n_fail++; $display("FAIL held_single: got extra_starts=%0d pend=%b expected 0 0000", nstart, bif.pending);
        end
        bif.req_in = '0;
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int nstart;
        do_reset('0);
        tick();
        pulse_req(4'b0011);
        wait_start(ok);
        tick();                      // now in WAIT, channel 1 still pending
        #3 rst = 1'b1;
        #1;
        n_chk++;
        if ({bif.start, bif.busy, bif.grant_id, bif.pending, bif.overrun, bif.timeout_err} !== '0) begin
            n_fail++; $display("FAIL async_reset: got %b expected all zero",
                {bif.start, bif.busy, bif.grant_id, bif.pending, bif.overrun, bif.timeout_err});
        end
        tick();
        rst = 1'b0;
        nstart = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bif.start === 1'b1 || bif.timeout_err === 1'b1) nstart++;
        end
        n_chk++;
        if (nstart !== 0 || bif.pending !== 4'b0000) begin
            n_fail++; $display("FAIL reset_quiet: got events=%0d pend=%b expected 0 0000", nstart, bif.pending);
        end
        pulse_req(4'b0100);
        wait_start(ok);
        n_chk++;
        if (!ok || bif.grant_id !== 2'd2) begin n_fail++; $display("FAIL reset_new_req: got started=%0d id=%0d expected 1 2", ok, bif.grant_id); end
        tick();
        pulse_done();
    endtask

    initial begin
        bif.req_in = '0;
        bif.done = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_overrun();
        test_set_wins();
        test_boundary();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
